// File: rtl/hit_judge_pkg.sv
// Shared constants for the hit judge: lane FSM states, zone codes shown on
// the HEX display, and the points awarded per timing band.
package hit_judge_pkg;

  // Lane controller states.
  typedef enum logic {
    LANE_IDLE   = 1'b0,
    LANE_ACTIVE = 1'b1
  } lane_state_t;

  // Zone codes reported per lane (2 bits each on lane_zone).
  localparam logic [1:0] ZONE_IDLE    = 2'd0;
  localparam logic [1:0] ZONE_LATE    = 2'd1;
  localparam logic [1:0] ZONE_GOOD    = 2'd2;
  localparam logic [1:0] ZONE_PERFECT = 2'd3;

  // Points awarded for a press in each timing band.
  localparam logic [1:0] PTS_PERFECT = 2'd3;
  localparam logic [1:0] PTS_GOOD    = 2'd2;
  localparam logic [1:0] PTS_LATE    = 2'd1;

endpackage

// File: rtl/hit_judge_lane.sv
// One arrow lane: idle/active controller, elapsed-cycle timer and press
// edge detector. Reports this cycle's graded press or timeout to the parent
// combinationally so the parent can fold all lanes into one counter update.
module hit_lane
  import hit_judge_pkg::*;
#(
  parameter int CNT_W     = 27,
  parameter int WINDOW    = 50_000_000,
  parameter int PERFECT_T = 5_000_000,
  parameter int GOOD_T    = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm,
  input  logic       hit,
  output logic       press,
  output logic       miss,
  output logic [1:0] pts,
  output logic [1:0] zone
);

  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] PERFECT_C = CNT_W'(PERFECT_T);
  localparam logic [CNT_W-1:0] GOOD_C    = CNT_W'(GOOD_T);

  lane_state_t      state_reg;
  logic [CNT_W-1:0] e_reg;
  logic             hit_q_reg;
  logic [1:0]       zone_reg;

  logic             rise_w;
  logic             active_w;
  logic             last_w;
  logic [CNT_W-1:0] e_inc;

  // Display zone for a given elapsed count while the lane is active.
  function automatic logic [1:0] band_of(input logic [CNT_W-1:0] e);
    if (e < PERFECT_C)   return ZONE_PERFECT;
    else if (e < GOOD_C) return ZONE_GOOD;
    else                 return ZONE_LATE;
  endfunction

  // Points for a press landing at a given elapsed count.
  function automatic logic [1:0] points_of(input logic [CNT_W-1:0] e);
    if (e < PERFECT_C)   return PTS_PERFECT;
    else if (e < GOOD_C) return PTS_GOOD;
    else                 return PTS_LATE;
  endfunction

  // Detect a fresh press and the last window cycle; a press on the last
  // cycle takes precedence over the timeout.
  always_comb begin
    rise_w   = hit & ~hit_q_reg;
    active_w = (state_reg == LANE_ACTIVE);
    last_w   = (e_reg == LAST_C);
    press    = active_w & rise_w;
    miss     = active_w & last_w & ~rise_w;
    pts      = press ? points_of(e_reg) : 2'd0;
    e_inc    = e_reg + CNT_W'(1);
  end

  // Lane FSM: arm starts a window, press or timeout ends it; zone follows
  // the state and timer so it is registered alongside them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= LANE_IDLE;
      e_reg     <= '0;
      hit_q_reg <= 1'b0;
      zone_reg  <= ZONE_IDLE;
    end else begin
      hit_q_reg <= hit;
      case (state_reg)
        LANE_IDLE: begin
          if (arm) begin
            state_reg <= LANE_ACTIVE;
            e_reg     <= '0;
            zone_reg  <= band_of('0);
          end
        end
        LANE_ACTIVE: begin
          if (press || last_w) begin
            state_reg <= LANE_IDLE;
            e_reg     <= '0;
            zone_reg  <= ZONE_IDLE;
          end else begin
            e_reg    <= e_inc;
            zone_reg <= band_of(e_inc);
          end
        end
        default: begin
          state_reg <= LANE_IDLE;
          e_reg     <= '0;
          zone_reg  <= ZONE_IDLE;
        end
      endcase
    end
  end

  assign zone = zone_reg;

endmodule

// File: rtl/hit_judge.sv
// Rhythm-game hit judge: LANES independent reaction windows whose graded
// presses and timeouts are summed each cycle into saturating score, combo
// and miss counters, with a one-cycle event pulse per update.
module hit_judge
  import hit_judge_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int CNT_W     = 27,
  parameter int WINDOW    = 50_000_000,
  parameter int PERFECT_T = 5_000_000,
  parameter int GOOD_T    = 25_000_000,
  parameter int SCORE_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 score_clr,
  input  logic [LANES-1:0]     arm,
  input  logic [LANES-1:0]     hit,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   combo,
  output logic [SCORE_W-1:0]   miss_cnt,
  output logic [2*LANES-1:0]   lane_zone,
  output logic                 evt_valid,
  output logic [LANES-1:0]     evt_hits,
  output logic [LANES-1:0]     evt_miss
);

  // Wide enough for counter + 3 points from each of up to 8 lanes.
  localparam int SUM_W = SCORE_W + 6;
  localparam logic [SUM_W-1:0] SAT_C = SUM_W'({SCORE_W{1'b1}});

  logic [LANES-1:0]        press_w;
  logic [LANES-1:0]        miss_w;
  logic [LANES-1:0][1:0]   pts_w;

  logic [SUM_W-1:0]   pts_sum;
  logic [SUM_W-1:0]   hit_n;
  logic [SUM_W-1:0]   miss_n;
  logic [SCORE_W-1:0] score_base;
  logic [SCORE_W-1:0] combo_base;
  logic [SCORE_W-1:0] miss_base;
  logic [SCORE_W-1:0] score_next;
  logic [SCORE_W-1:0] combo_next;
  logic [SCORE_W-1:0] miss_next;

  logic [SCORE_W-1:0] score_reg;
  logic [SCORE_W-1:0] combo_reg;
  logic [SCORE_W-1:0] miss_reg;
  logic               evt_valid_reg;
  logic [LANES-1:0]   evt_hits_reg;
  logic [LANES-1:0]   evt_miss_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      hit_lane #(
        .CNT_W     (CNT_W),
        .WINDOW    (WINDOW),
        .PERFECT_T (PERFECT_T),
        .GOOD_T    (GOOD_T)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .arm   (arm[gi]),
        .hit   (hit[gi]),
        .press (press_w[gi]),
        .miss  (miss_w[gi]),
        .pts   (pts_w[gi]),
        .zone  (lane_zone[2*gi +: 2])
      );
    end
  endgenerate

  // Clamp a widened sum back to the counter width.
  function automatic logic [SCORE_W-1:0] sat(input logic [SUM_W-1:0] v);
    if (v > SAT_C) return {SCORE_W{1'b1}};
    else           return v[SCORE_W-1:0];
  endfunction

  // Sum every lane's contribution this cycle so simultaneous events land
  // in a single update; a clear restarts the counters from zero first.
  always_comb begin
    pts_sum = '0;
    hit_n   = '0;
    miss_n  = '0;
    for (int i = 0; i < LANES; i++) begin
      pts_sum = pts_sum + SUM_W'(pts_w[i]);
      hit_n   = hit_n + SUM_W'(press_w[i]);
      miss_n  = miss_n + SUM_W'(miss_w[i]);
    end
    score_base = score_clr ? '0 : score_reg;
    combo_base = score_clr ? '0 : combo_reg;
    miss_base  = score_clr ? '0 : miss_reg;
    score_next = sat(SUM_W'(score_base) + pts_sum);
    combo_next = (|miss_w) ? '0 : sat(SUM_W'(combo_base) + hit_n);
    miss_next  = sat(SUM_W'(miss_base) + miss_n);
  end

  // Counter and event registers, updated one edge after detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_reg     <= '0;
      combo_reg     <= '0;
      miss_reg      <= '0;
      evt_valid_reg <= 1'b0;
      evt_hits_reg  <= '0;
      evt_miss_reg  <= '0;
    end else begin
      score_reg     <= score_next;
      combo_reg     <= combo_next;
      miss_reg      <= miss_next;
      evt_valid_reg <= (|press_w) | (|miss_w);
      evt_hits_reg  <= press_w;
      evt_miss_reg  <= miss_w;
    end
  end

  assign score     = score_reg;
  assign combo     = combo_reg;
  assign miss_cnt  = miss_reg;
  assign evt_valid = evt_valid_reg;
  assign evt_hits  = evt_hits_reg;
  assign evt_miss  = evt_miss_reg;

endmodule

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 SHALL have parameter LANES, 4, number of independent arrow lanes (1..8).
REQ-002 SHALL have parameter CNT_W, 27, lane timer width.
REQ-003 SHALL have parameter WINDOW, 50_000_000, reaction window length in cycles (< 2**CNT_W).
REQ-004 SHALL have parameter PERFECT_T, 5_000_000, elapsed-cycle bound for PERFECT grade (PERFECT_T < GOOD_T).
REQ-005 SHALL have parameter GOOD_T, 25_000_000, elapsed-cycle bound for GOOD grade (GOOD_T < WINDOW).
REQ-006 SHALL have parameter SCORE_W, 8, width of score, combo, miss counters.
REQ-007 SHALL have ports: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have ports: score_clr  in  1  clear score/combo/miss; arm  in  LANES  per-lane window start pulse; hit  in  LANES  per-lane press level (button OR pad, pre-synchronised).
REQ-009 SHALL have ports: score  out  SCORE_W; combo  out  SCORE_W; miss_cnt  out  SCORE_W.
REQ-010 SHALL have ports: lane_zone  out  2*LANES  per-lane zone code (0 idle, 1 late, 2 good, 3 perfect) for HEX display.
REQ-011 SHALL have ports: evt_valid  out  1  one-cycle event pulse; evt_hits  out  LANES  lanes hit this event; evt_miss  out  LANES  lanes missed this event.

Function
REQ-012 Each lane SHALL run FSM IDLE -> ACTIVE -> IDLE with elapsed timer e (0 on entry to ACTIVE).
REQ-013 arm[i] in IDLE SHALL enter ACTIVE next cycle with e=0; arm[i] while ACTIVE SHALL be ignored (no restart).
REQ-014 A press SHALL be a rising edge of hit[i] (hit & ~hit_q); held levels SHALL never score twice; presses in IDLE SHALL be ignored, no penalty.
REQ-015 Press in ACTIVE SHALL grade: e < PERFECT_T -> 3 points; PERFECT_T <= e < GOOD_T -> 2; GOOD_T <= e <= WINDOW-1 -> 1; lane returns to IDLE next cycle.
REQ-016 If e reaches WINDOW-1 with no press, lane SHALL return to IDLE next cycle and flag a miss; a press in that same cycle SHALL win (graded 1, no miss).
REQ-017 lane_zone[i] SHALL be 0 in IDLE, else 3/2/1 per the e-bands of REQ-015, registered with the lane state.
REQ-018 All lanes' points in one cycle SHALL be summed and added in one update; no simultaneous hit SHALL be lost.
REQ-019 score, combo, miss_cnt SHALL update the clock edge after press/timeout detection (1-cycle latency) and SHALL saturate at 2**SCORE_W-1.
REQ-020 combo SHALL add the number of hitting lanes; any miss in the same cycle SHALL force combo to 0.
REQ-021 miss_cnt SHALL add the number of missing lanes per cycle.
REQ-022 score_clr SHALL zero score, combo, miss_cnt, then add that cycle's contributions; lane timers SHALL be unaffected.
REQ-023 evt_valid SHALL pulse for one cycle, aligned with the counter update, when any hit or miss occurs, with evt_hits/evt_miss bitmaps.

Reset
REQ-024 reset SHALL force all lanes IDLE, e=0, hit_q=0, score=combo=miss_cnt=0, lane_zone=0, evt_valid=0, evt_hits=evt_miss=0.
REQ-025 reset SHALL override score_clr, arm and hit; reset mid-window SHALL abort without scoring or miss.

Structure
REQ-026 Package hit_judge_pkg SHALL hold zone codes (ZONE_IDLE/LATE/GOOD/PERFECT) and point constants (3/2/1).
REQ-027 Per-lane FSM/timer/edge-detect SHALL be sub-module hit_lane, instantiated LANES times; summation and saturation stay in hit_judge.

Verification (WINDOW=100, PERFECT_T=20, GOOD_T=60, LANES=4, SCORE_W=8)
REQ-028 arm[0], press at e=10 -> score 3, combo 1, evt_hits=0001, lane_zone[0] 3 then 0.
REQ-029 arm[1], no press -> after 100 cycles miss_cnt 1, combo 0, evt_miss=0010; press at e=99 instead -> score +1, no miss.
REQ-030 arm all 4, presses same cycle at e=30 -> score +8 in one cycle, combo +4, evt_hits=1111.
REQ-031 hit[2] held high across arm -> no score; release and press at e=70 -> score +1.
REQ-032 score at 254, PERFECT press -> score 255 (saturated); score_clr with simultaneous GOOD press -> score 2.
REQ-033 reset asserted at e=50 in lane 3 -> lane_zone 0, no miss, all counters 0; re-arm works normally.
